// File: rtl/axis_i2c_rx_packer.sv
// Packs synchronized I2C read bytes little-endian into AXI-Stream words and
// buffers them in a first-word-fall-through FIFO with sticky overflow tracking.
module axis_i2c_rx_packer #(
    parameter int I2C_DATA_WIDTH = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     arstn_i,
    input  logic                                     en_i,
    input  logic                                     flush_i,
    input  logic [I2C_DATA_WIDTH-1:0]                i2c_tdata_i,
    input  logic                                     i2c_tvalid_i,
    output logic [BYTES_PER_WORD*I2C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BYTES_PER_WORD-1:0]                m_axis_tkeep,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]               level_o,
    output logic                                     overflow_o,
    input  logic                                     overflow_clr_i
);

    localparam int WW = BYTES_PER_WORD * I2C_DATA_WIDTH;
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = WW + BYTES_PER_WORD + 1;

    typedef enum logic {IDLE, FILL} state_e;

    // Reset asserts asynchronously and is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [2:0] tv_sync_q;
    logic       byte_evt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) tv_sync_q <= '0;
        else        tv_sync_q <= {tv_sync_q[1:0], i2c_tvalid_i};
    end
    assign byte_evt = tv_sync_q[1] & ~tv_sync_q[2] & en_i;

    state_e                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [WW-1:0]             word_q, word_d;
    logic [BYTES_PER_WORD-1:0] keep_q, keep_d;

    logic [WW-1:0]             merged_word;
    logic [BYTES_PER_WORD-1:0] merged_keep;
    logic [CW-1:0]             merged_count;
    logic                      push, push_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            word_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timer_d      = timer_q;
        word_d       = word_q;
        keep_d       = keep_q;
        push         = 1'b0;
        push_last    = 1'b0;
        merged_word  = word_q;
        merged_keep  = keep_q;
        merged_count = count_q;

        if (byte_evt) begin
            merged_word  = word_q | (WW'(i2c_tdata_i) << (int'(count_q) * I2C_DATA_WIDTH));
            merged_keep  = keep_q | (BYTES_PER_WORD'(1) << count_q);
            merged_count = count_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (byte_evt) begin
                    word_d  = merged_word;
                    keep_d  = merged_keep;
                    count_d = merged_count;
                    timer_d = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Flush takes precedence and marks tlast even when the byte completes the word.
                if (flush_i || (byte_evt && merged_count == CW'(BYTES_PER_WORD))) begin
                    push      = 1'b1;
                    push_last = flush_i;
                end else if (byte_evt) begin
                    word_d  = merged_word;
                    keep_d  = merged_keep;
                    count_d = merged_count;
                    timer_d = '0;
                end else if (en_i) begin
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                if (push) begin
                    word_d  = '0;
                    keep_d  = '0;
                    count_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          empty, full, pop, accept, drop;
    logic [EW-1:0] head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign pop    = ~empty & m_axis_tready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {push_last, merged_keep, merged_word};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (accept && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !accept) level_q <= level_q - LW'(1);
            if (drop)                overflow_q <= 1'b1;
            else if (overflow_clr_i) overflow_q <= 1'b0;
        end
    end

    // Outputs are forced to zero while empty so stale storage never leaks out.
    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? '0 : head[WW-1:0];
    assign m_axis_tkeep  = empty ? '0 : head[WW +: BYTES_PER_WORD];
    assign m_axis_tlast  = empty ? 1'b0 : head[EW-1];
    assign level_o       = level_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_axis_i2c_rx_packer.sv
// Scoreboard bench: a byte-list reference model predicts each output beat,
// and an independent monitor compares beats as the consumer accepts them.
module tb_axis_i2c_rx_packer;

    localparam int W     = 8;
    localparam int BPW   = 4;
    localparam int DEPTH = 8;
    localparam int T     = 1024;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          en = 1'b1;
    logic          flush = 1'b0;
    logic [W-1:0]  tdata_in = '0;
    logic          tvalid_in = 1'b0;
    logic          tready_drv = 1'b0;
    logic          rnd_mode = 1'b0;
    logic          rnd_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          tready;

    logic [BPW*W-1:0] m_tdata;
    logic [BPW-1:0]   m_tkeep;
    logic             m_tlast;
    logic             m_tvalid;
    logic [3:0]       level;
    logic             overflow;

    assign tready = rnd_mode ? rnd_ready : tready_drv;

    axis_i2c_rx_packer #(
        .I2C_DATA_WIDTH(W), .BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .en_i(en), .flush_i(flush),
        .i2c_tdata_i(tdata_in), .i2c_tvalid_i(tvalid_in),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(tready),
        .level_o(level), .overflow_o(overflow), .overflow_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BPW*W-1:0] data;
        logic [BPW-1:0]   keep;
        logic             last;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] pend[$];
    int           exp_level = 0;
    logic         exp_ovf = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;
    beat_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Closes the pending byte list into one expected beat, honouring FIFO capacity.
    function automatic void emit(input logic last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last;
        foreach (pend[i]) begin
            b.data = b.data | ((BPW*W)'(pend[i]) << (8 * i));
            b.keep = b.keep | BPW'(1 << i);
        end
        pend.delete();
        if (exp_level < DEPTH) begin
            exp_q.push_back(b);
            exp_level++;
        end else begin
            exp_ovf = 1'b1;
        end
    endfunction

    function automatic void model_byte(input logic [W-1:0] b);
        pend.push_back(b);
        if (pend.size() == BPW) emit(1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [W-1:0] b, input int hold, input bit model);
        if (model) model_byte(b);
        tdata_in  = b;
        tvalid_in = 1'b1;
        repeat (hold) tick();
        tvalid_in = 1'b0;
        repeat (3 + $urandom_range(0, 2)) tick();
    endtask

    task automatic drain();
        tready_drv = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("drain_sb_empty", 64'(exp_q.size()), 0);
        check("drain_level", 64'(level), 0);
        tready_drv = 1'b0;
    endtask

    always begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (arstn && m_tvalid && tready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                exp_level--;
                check("beat_tdata", 64'(m_tdata), 64'(mon_e.data));
                check("beat_tkeep", 64'(m_tkeep), 64'(mon_e.keep));
                check("beat_tlast", 64'(m_tlast), 64'(mon_e.last));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] b;
        int n;

        // Reset state
        arstn = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", 64'(m_tvalid), 0);
        check("rst_tdata", 64'(m_tdata), 0);
        check("rst_tkeep", 64'(m_tkeep), 0);
        check("rst_tlast", 64'(m_tlast), 0);
        check("rst_level", 64'(level), 0);
        check("rst_overflow", 64'(overflow), 0);
        arstn = 1'b1;
        repeat (4) tick();

        // Full word 11,22,33,44 with latency measured from the 4th raw rise
        send_byte(8'h11, 3, 1);
        send_byte(8'h22, 3, 1);
        send_byte(8'h33, 3, 1);
        model_byte(8'h44);
        tdata_in  = 8'h44;
        tvalid_in = 1'b1;
        tick();
        tick();
        check("lat_before_3", 64'(m_tvalid), 0);
        tick();
        check("lat_at_3", 64'(m_tvalid), 1);
        tvalid_in = 1'b0;
        repeat (3) tick();
        check("word1_level", 64'(level), 1);
        drain();

        // Partial word closed by timeout
        send_byte(8'hAA, 3, 1);
        pend.push_back(8'hBB);
        tdata_in  = 8'hBB;
        tvalid_in = 1'b1;
        repeat (3) tick();
        tvalid_in = 1'b0;
        repeat (T - 1) tick();
        check("timeout_not_early", 64'(m_tvalid), 0);
        emit(1'b1);
        tick();
        check("timeout_fires", 64'(m_tvalid), 1);
        drain();

        // Overflow: nine full words into an eight-deep FIFO with no consumer
        for (int w = 0; w < DEPTH + 1; w++)
            for (int k = 0; k < BPW; k++)
                send_byte(8'(w * BPW + k + 1), 3, 1);
        repeat (5) tick();
        check("ovf_level", 64'(level), 64'(exp_level));
        check("ovf_level_full", 64'(level), DEPTH);
        check("ovf_flag", 64'(overflow), 64'(exp_ovf));
        drain();
        check("ovf_sticky", 64'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'(exp_ovf));

        // Flush coincident with the byte that completes the word
        send_byte(8'h01, 3, 1);
        send_byte(8'h02, 3, 1);
        send_byte(8'h03, 3, 1);
        pend.push_back(8'h04);
        emit(1'b1);
        tdata_in  = 8'h04;
        tvalid_in = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tvalid_in = 1'b0;
        repeat (3) tick();
        check("flush_coinc_level", 64'(level), 1);
        drain();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check("flush_idle_no_beat", 64'(m_tvalid), 0);
        check("flush_idle_level", 64'(level), 0);

        // Long-held valid yields a single byte
        send_byte(8'h5A, 500, 1);
        for (int k = 0; k < BPW - 1; k++) send_byte(8'($urandom), 3, 1);
        drain();

        // en_i low: byte ignored and timer frozen
        send_byte(8'hC3, 3, 1);
        en = 1'b0;
        send_byte(8'hEE, 3, 0);
        repeat (T + 100) tick();
        check("en0_no_beat", 64'(m_tvalid), 0);
        en = 1'b1;
        for (int k = 0; k < BPW - 1; k++) send_byte(8'($urandom), 3, 1);
        drain();

        // Randomized traffic with a randomly stalling consumer
        rnd_mode = 1'b1;
        for (int w = 0; w < 24; w++) begin
            n = $urandom_range(1, BPW);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_byte(b, $urandom_range(3, 6), 1);
            end
            if (n < BPW) begin
                emit(1'b1);
                if (w % 8 == 3) begin
                    repeat (T + 4) tick();
                end else begin
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                    repeat (2) tick();
                end
            end
        end
        drain();
        rnd_mode = 1'b0;

        // Asynchronous reset mid-word with two words queued
        for (int k = 0; k < 2 * BPW + 2; k++) send_byte(8'(8'h80 + k), 3, 1);
        repeat (3) tick();
        check("prerst_level", 64'(level), 2);
        #2;
        arstn = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_tvalid), 0);
        check("arst_tdata", 64'(m_tdata), 0);
        check("arst_tkeep", 64'(m_tkeep), 0);
        check("arst_tlast", 64'(m_tlast), 0);
        check("arst_level", 64'(level), 0);
        check("arst_overflow", 64'(overflow), 0);
        exp_q.delete();
        pend.delete();
        exp_level = 0;
        exp_ovf   = 1'b0;
        repeat (2) tick();
        arstn = 1'b1;
        repeat (4) tick();
        send_byte(8'hD1, 3, 1);
        send_byte(8'hD2, 3, 1);
        send_byte(8'hD3, 3, 1);
        send_byte(8'hD4, 3, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
